// File: rtl/line_buf_pkg.sv
// rtl/line_buf_pkg.sv - shared types and helpers for the N-line buffer controller
package line_buf_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FILL   = 2'd1,
        STREAM = 2'd2,
        FLUSH  = 2'd3
    } lb_state_e;

    // Rows the write side runs ahead of the centre row being read.
    function automatic int lag_of(input int n_lines);
        return (n_lines - 1) / 2;
    endfunction

    // Counter width able to hold 0..n-1, never narrower than one bit.
    function automatic int cnt_wd(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/line_pos_cnt.sv
// rtl/line_pos_cnt.sv - column/row/RAM-index position counter for one side of the line buffer
//
// Ports:
//   clk_i, rst_ni   clock, asynchronous active-low reset
//   advance         step one pixel position forward
//   clear           return to (row 0, col 0, ram 0); with advance, steps from origin
//   col, row, ram   current position
//   end_of_line     col is the last column
//   end_of_frame    row is the last row of the frame
module line_pos_cnt
    import line_buf_pkg::*;
#(
    parameter  int IMG_W   = 640,
    parameter  int IMG_H   = 480,
    parameter  int N_LINES = 3,
    localparam int COL_WD  = cnt_wd(IMG_W),
    localparam int ROW_WD  = cnt_wd(IMG_H),
    localparam int RAM_WD  = cnt_wd(N_LINES)
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              advance,
    input  logic              clear,
    output logic [COL_WD-1:0] col,
    output logic [ROW_WD-1:0] row,
    output logic [RAM_WD-1:0] ram,
    output logic              end_of_line,
    output logic              end_of_frame
);

    logic [COL_WD-1:0] base_col, next_col;
    logic [ROW_WD-1:0] base_row, next_row;
    logic [RAM_WD-1:0] base_ram, next_ram;

    assign end_of_line  = (col == COL_WD'(IMG_W - 1));
    assign end_of_frame = (row == ROW_WD'(IMG_H - 1));

    always_comb begin
        // clear and advance together means "this pixel is the origin", so the
        // step is taken from zero rather than from the current position.
        base_col = clear ? '0 : col;
        base_row = clear ? '0 : row;
        base_ram = clear ? '0 : ram;
        next_col = base_col;
        next_row = base_row;
        next_ram = base_ram;
        if (advance) begin
            if (base_col == COL_WD'(IMG_W - 1)) begin
                next_col = '0;
                next_row = (base_row == ROW_WD'(IMG_H - 1)) ? '0 : base_row + ROW_WD'(1);
                // N_LINES need not be a power of two, so wrap explicitly.
                next_ram = (base_ram == RAM_WD'(N_LINES - 1)) ? '0 : base_ram + RAM_WD'(1);
            end else begin
                next_col = base_col + COL_WD'(1);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            col <= '0;
            row <= '0;
            ram <= '0;
        end else begin
            col <= next_col;
            row <= next_row;
            ram <= next_ram;
        end
    end

endmodule

// File: rtl/line_buffer_ctrl_n.sv
// rtl/line_buffer_ctrl_n.sv - write/read address controller for an N-line circular line buffer
//
// Ports:
//   clk_i, rst_ni            clock, asynchronous active-low reset
//   pix_i, pix_valid_i       incoming pixel and its valid
//   pix_ready_o              pixel accepted when valid & ready (low only while flushing)
//   sof_i                    marks the accepted pixel as (row 0, col 0)
//   wdata_o, waddr_o, wsel_o registered line-RAM write port, wsel_o one-hot enable
//   raddr_o, rd_en_o         registered read address (all RAMs) and read strobe
//   rd_base_o                RAM index holding the centre row being read
//   first_line_o/last_line_o centre row is the first/last row of the frame
//   first_col_o/last_col_o   read column is the first/last column
//   frame_done_o             one-cycle pulse the cycle after the final read
module line_buffer_ctrl_n
    import line_buf_pkg::*;
#(
    parameter int DATA_WD = 8,
    parameter int IMG_W   = 640,
    parameter int IMG_H   = 480,
    parameter int N_LINES = 3,
    parameter int ADDR_WD = $clog2(IMG_W),
    parameter int SEL_WD  = $clog2(N_LINES)
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic [DATA_WD-1:0] pix_i,
    input  logic               pix_valid_i,
    output logic               pix_ready_o,
    input  logic               sof_i,
    output logic [DATA_WD-1:0] wdata_o,
    output logic [ADDR_WD-1:0] waddr_o,
    output logic [N_LINES-1:0] wsel_o,
    output logic [ADDR_WD-1:0] raddr_o,
    output logic               rd_en_o,
    output logic [SEL_WD-1:0]  rd_base_o,
    output logic               first_line_o,
    output logic               last_line_o,
    output logic               first_col_o,
    output logic               last_col_o,
    output logic               frame_done_o
);

    localparam int LAG = lag_of(N_LINES);
    localparam int CW  = cnt_wd(IMG_W);
    localparam int RW  = cnt_wd(IMG_H);
    localparam int SW  = cnt_wd(N_LINES);

    lb_state_e state_q, state_d;

    logic          accept, restart, fill_done, read_issue, flush_last;
    logic          done_pend_q;
    logic [CW-1:0] wr_col, rd_col;
    logic [RW-1:0] wr_row, rd_row;
    logic [SW-1:0] wr_ram, rd_ram;
    logic          wr_eol, wr_eof, rd_eol, rd_eof;

    assign pix_ready_o = (state_q != FLUSH);
    assign accept      = pix_valid_i & pix_ready_o;
    // sof can only be accepted outside FLUSH; in IDLE restarting is a no-op.
    assign restart     = accept & sof_i;
    // Write side is about to store (LAG, 0): the centre row 0 window is complete.
    assign fill_done   = (wr_row == RW'(LAG)) && (wr_col == '0);
    assign flush_last  = (state_q == FLUSH) && rd_eol && rd_eof;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        read_issue = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) state_d = FILL;
            end
            FILL: begin
                if (restart) begin
                    state_d = FILL;
                end else if (accept && fill_done) begin
                    state_d    = STREAM;
                    read_issue = 1'b1;
                end
            end
            STREAM: begin
                if (restart) begin
                    state_d = FILL;
                end else if (accept) begin
                    read_issue = 1'b1;
                    if (wr_eol && wr_eof) state_d = FLUSH;
                end
            end
            FLUSH: begin
                read_issue = 1'b1;
                if (rd_eol && rd_eof) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    line_pos_cnt #(
        .IMG_W   (IMG_W),
        .IMG_H   (IMG_H),
        .N_LINES (N_LINES)
    ) u_wr_pos (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .advance      (accept),
        .clear        (restart | flush_last),
        .col          (wr_col),
        .row          (wr_row),
        .ram          (wr_ram),
        .end_of_line  (wr_eol),
        .end_of_frame (wr_eof)
    );

    // The final flush read leaves the read side at origin instead of stepping past it.
    line_pos_cnt #(
        .IMG_W   (IMG_W),
        .IMG_H   (IMG_H),
        .N_LINES (N_LINES)
    ) u_rd_pos (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .advance      (read_issue & ~flush_last),
        .clear        (restart | flush_last),
        .col          (rd_col),
        .row          (rd_row),
        .ram          (rd_ram),
        .end_of_line  (rd_eol),
        .end_of_frame (rd_eof)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wdata_o      <= '0;
            waddr_o      <= '0;
            wsel_o       <= '0;
            raddr_o      <= '0;
            rd_en_o      <= 1'b0;
            rd_base_o    <= '0;
            first_line_o <= 1'b0;
            last_line_o  <= 1'b0;
            first_col_o  <= 1'b0;
            last_col_o   <= 1'b0;
            done_pend_q  <= 1'b0;
            frame_done_o <= 1'b0;
        end else begin
            wsel_o <= '0;
            if (accept) begin
                wdata_o <= pix_i;
                waddr_o <= restart ? '0 : ADDR_WD'(wr_col);
                wsel_o  <= restart ? N_LINES'(1) : (N_LINES'(1) << wr_ram);
            end
            raddr_o      <= ADDR_WD'(rd_col);
            rd_base_o    <= SEL_WD'(rd_ram);
            rd_en_o      <= read_issue;
            first_line_o <= read_issue && (rd_row == '0);
            last_line_o  <= read_issue && rd_eof;
            first_col_o  <= read_issue && (rd_col == '0);
            last_col_o   <= read_issue && rd_eol;
            // Final read appears on rd_en_o one cycle after issue; done follows it.
            done_pend_q  <= flush_last;
            frame_done_o <= done_pend_q;
        end
    end

endmodule

// File: tb/tb_line_buffer_ctrl_n.sv
// tb/tb_line_buffer_ctrl_n.sv - self-checking bench for line_buffer_ctrl_n (N_LINES 3 and 5)
module tb_line_buffer_ctrl_n;

    localparam int W = 8;
    localparam int H = 6;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [7:0] pix_a = '0, pix_b = '0;
    logic       valid_a = 1'b0, valid_b = 1'b0, sof_a = 1'b0, sof_b = 1'b0;
    logic       ready_a, ready_b;
    logic [7:0] wdata_a, wdata_b;
    logic [2:0] waddr_a, waddr_b, raddr_a, raddr_b;
    logic [2:0] wsel_a;
    logic [4:0] wsel_b;
    logic [1:0] base_a;
    logic [2:0] base_b;
    logic       rd_a, rd_b, fl_a, fl_b, ll_a, ll_b, fc_a, fc_b, lc_a, lc_b, done_a, done_b;

    int checks = 0, failures = 0;
    int rd_cnt = 0, wr_cnt = 0, done_cnt = 0;

    line_buffer_ctrl_n #(.DATA_WD(8), .IMG_W(W), .IMG_H(H), .N_LINES(3)) u_a (
        .clk_i(clk), .rst_ni(rst_n), .pix_i(pix_a), .pix_valid_i(valid_a),
        .pix_ready_o(ready_a), .sof_i(sof_a), .wdata_o(wdata_a), .waddr_o(waddr_a),
        .wsel_o(wsel_a), .raddr_o(raddr_a), .rd_en_o(rd_a), .rd_base_o(base_a),
        .first_line_o(fl_a), .last_line_o(ll_a), .first_col_o(fc_a), .last_col_o(lc_a),
        .frame_done_o(done_a)
    );

    line_buffer_ctrl_n #(.DATA_WD(8), .IMG_W(W), .IMG_H(H), .N_LINES(5)) u_b (
        .clk_i(clk), .rst_ni(rst_n), .pix_i(pix_b), .pix_valid_i(valid_b),
        .pix_ready_o(ready_b), .sof_i(sof_b), .wdata_o(wdata_b), .waddr_o(waddr_b),
        .wsel_o(wsel_b), .raddr_o(raddr_b), .rd_en_o(rd_b), .rd_base_o(base_b),
        .first_line_o(fl_b), .last_line_o(ll_b), .first_col_o(fc_b), .last_col_o(lc_b),
        .frame_done_o(done_b)
    );

    // Observation vector: {wsel[27:23], waddr[22:20], wdata[19:12], rd_en[11],
    //                      raddr[10:8], base[7:5], first_line, last_line, first_col, last_col, done}
    function automatic logic [27:0] mk(input logic [4:0] ws, input logic [2:0] wa,
                                       input logic [7:0] wd, input logic rd,
                                       input logic [2:0] ra, input logic [2:0] rb,
                                       input logic [4:0] fl);
        return {ws, wa, wd, rd, ra, rb, fl};
    endfunction

    function automatic logic [27:0] get_vec(input int d);
        if (d == 0)
            return mk({2'b00, wsel_a}, waddr_a, wdata_a, rd_a, raddr_a, {1'b0, base_a},
                      {fl_a, ll_a, fc_a, lc_a, done_a});
        return mk(wsel_b, waddr_b, wdata_b, rd_b, raddr_b, base_b,
                  {fl_b, ll_b, fc_b, lc_b, done_b});
    endfunction

    function automatic logic get_ready(input int d);
        return (d == 0) ? ready_a : ready_b;
    endfunction

    // Write data/address are only meaningful with a write, read address/base with a read.
    function automatic logic [27:0] mask_of(input logic [27:0] e);
        logic [27:0] m;
        m = 28'hfffffff;
        if (e[27:23] == 5'd0) m[22:12] = '0;
        if (!e[11]) m[10:5] = '0;
        return m;
    endfunction

    // Read of centre pixel (cr, c) on an N-line buffer.
    function automatic logic [27:0] read_part(input int n, input int cr, input int c);
        return mk(5'd0, 3'd0, 8'd0, 1'b1, 3'(c), 3'(cr % n),
                  {cr == 0, cr == H - 1, c == 0, c == W - 1, 1'b0});
    endfunction

    // Expected outputs for the k-th accepted pixel of a frame.
    function automatic logic [27:0] pix_exp(input int n, input int k, input logic [7:0] p);
        int r, c, lag;
        logic [27:0] e;
        r   = k / W;
        c   = k % W;
        lag = (n - 1) / 2;
        e   = mk(5'(1 << (r % n)), 3'(c), p, 1'b0, 3'd0, 3'd0, 5'd0);
        if (r >= lag) e = e | read_part(n, r - lag, c);
        return e;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_vec(input string name, input int d, input logic [27:0] e);
        logic [27:0] a, m;
        a = get_vec(d);
        m = mask_of(e);
        if (a[11]) rd_cnt++;
        if (a[27:23] != 5'd0) wr_cnt++;
        if (a[0]) done_cnt++;
        check(name, 32'(a & m), 32'(e & m));
    endtask

    task automatic set_in(input int d, input logic v, input logic s, input logic [7:0] p);
        if (d == 0) begin
            valid_a = v; sof_a = s; pix_a = p;
        end else begin
            valid_b = v; sof_b = s; pix_b = p;
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        set_in(0, 1'b0, 1'b0, 8'd0);
        set_in(1, 1'b0, 1'b0, 8'd0);
        step();
        step();
        rst_n = 1'b1;
        step();
    endtask

    // Feed pixels 0..k1-1 with random gaps; sof_first marks pixel 0.
    task automatic feed(input int d, input int n, input int k1, input int gap_pct,
                        input logic sof_first, input string tag);
        int k, guard;
        logic v;
        logic [7:0] p;
        k = 0;
        guard = 0;
        while (k < k1 && guard < 4000) begin
            guard++;
            v = ($urandom_range(99) >= 32'(gap_pct));
            p = 8'($urandom);
            check({tag, " ready"}, 32'(get_ready(d)), 32'd1);
            set_in(d, v, sof_first && (k == 0), p);
            step();
            if (v) begin
                check_vec($sformatf("%s pix%0d", tag, k), d, pix_exp(n, k, p));
                k++;
            end else begin
                check_vec({tag, " gap"}, d, 28'd0);
            end
        end
        if (k < k1) check({tag, " feed budget"}, 32'(k), 32'(k1));
        set_in(d, 1'b0, 1'b0, 8'd0);
    endtask

    // Valid is held high while flushing to prove nothing is accepted.
    task automatic flush(input int d, input int n, input int ncyc, input string tag);
        int lag;
        lag = (n - 1) / 2;
        for (int j = 0; j < ncyc; j++) begin
            check({tag, " flush ready"}, 32'(get_ready(d)), 32'd0);
            set_in(d, 1'b1, 1'b0, 8'($urandom));
            step();
            check_vec($sformatf("%s flush%0d", tag, j), d, read_part(n, H - lag + j / W, j % W));
        end
        set_in(d, 1'b0, 1'b0, 8'd0);
    endtask

    task automatic frame(input int d, input int n, input int gap_pct, input logic sof_first,
                         input string tag);
        int lag;
        lag = (n - 1) / 2;
        rd_cnt = 0;
        wr_cnt = 0;
        done_cnt = 0;
        feed(d, n, W * H, gap_pct, sof_first, tag);
        check({tag, " stream reads"}, 32'(rd_cnt), 32'(W * (H - lag)));
        flush(d, n, lag * W, tag);
        check({tag, " total reads"}, 32'(rd_cnt), 32'(W * H));
        check({tag, " ready after flush"}, 32'(get_ready(d)), 32'd1);
        step();
        check_vec({tag, " done"}, d, 28'd1);
        step();
        check_vec({tag, " idle"}, d, 28'd0);
        check({tag, " writes"}, 32'(wr_cnt), 32'(W * H));
        check({tag, " done pulses"}, 32'(done_cnt), 32'd1);
    endtask

    typedef struct {
        logic        v;
        logic [7:0]  p;
        logic [27:0] e;
    } tv_t;

    initial begin
        tv_t tbl[11];
        for (int i = 0; i < 8; i++) begin
            tbl[i].v = 1'b1;
            tbl[i].p = 8'(8'h30 + i);
            tbl[i].e = mk(5'b00001, 3'(i), tbl[i].p, 1'b0, 3'd0, 3'd0, 5'b00000);
        end
        tbl[8].v  = 1'b0; tbl[8].p  = 8'hee; tbl[8].e = 28'd0;
        tbl[9].v  = 1'b1; tbl[9].p  = 8'h5a;
        tbl[9].e  = mk(5'b00010, 3'd0, 8'h5a, 1'b1, 3'd0, 3'd0, 5'b10100);
        tbl[10].v = 1'b1; tbl[10].p = 8'ha5;
        tbl[10].e = mk(5'b00010, 3'd1, 8'ha5, 1'b1, 3'd1, 3'd0, 5'b10000);

        rst_n = 1'b0;
        step();
        for (int d = 0; d < 2; d++) begin
            check($sformatf("reset outputs d%0d", d), 32'(get_vec(d)), 32'd0);
            check($sformatf("reset ready d%0d", d), 32'(get_ready(d)), 32'd1);
        end
        rst_n = 1'b1;
        step();

        for (int i = 0; i < 11; i++) begin
            set_in(0, tbl[i].v, 1'b0, tbl[i].p);
            step();
            check($sformatf("fill table %0d", i), 32'(get_vec(0) & mask_of(tbl[i].e)),
                  32'(tbl[i].e & mask_of(tbl[i].e)));
        end
        set_in(0, 1'b0, 1'b0, 8'd0);

        do_reset();
        frame(0, 3, 0, 1'b0, "n3 full");
        frame(0, 3, 40, 1'b0, "n3 gaps");

        do_reset();
        frame(1, 5, 0, 1'b0, "n5 full");
        frame(1, 5, 35, 1'b1, "n5 gaps sof_idle");

        do_reset();
        feed(0, 3, 20, 0, 1'b0, "pre sof");
        feed(0, 3, W * H, 25, 1'b1, "sof frame");
        flush(0, 3, 3, "abort");
        rst_n = 1'b0;
        #1;
        check("async reset outputs", 32'(get_vec(0)), 32'd0);
        check("async reset ready", 32'(get_ready(0)), 32'd1);
        for (int i = 0; i < 2; i++) begin
            step();
            check($sformatf("held reset %0d", i), 32'(get_vec(0)), 32'd0);
        end
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check_vec($sformatf("no done after reset %0d", i), 0, 28'd0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

endmodule
